// File: rtl/pattern_writer.sv
// Wishbone write master that fills the framebuffer with a selectable test pattern,
// one pixel per ack, releasing the bus for GAP cycles after every BURST-ack tenure.
module pattern_writer #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64,
  parameter int GAP   = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  // Pixel counters are at least 8 bits wide so the pattern bit taps always exist.
  localparam int XW      = ($clog2(HDISP) > 8) ? $clog2(HDISP) : 8;
  localparam int YW      = ($clog2(VDISP) > 8) ? $clog2(VDISP) : 8;
  localparam int BW      = $clog2(BURST + 1);
  localparam int GW      = $clog2(GAP + 1);
  localparam int BAR_LEN = HDISP / 8;
  localparam int PW      = $clog2(BAR_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [PW-1:0]   bar_pos_q, bar_pos_d;
  logic [2:0]      bar_q, bar_d;
  logic [1:0]      pat_q, pat_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            frame_done_q, frame_done_d;
  logic            last_q, last_d;
  logic            cyc_q, cyc_d;
  logic            last_pixel;
  logic            load_pixel;
  logic [23:0]     rgb;

  assign last_pixel = (x_q == XW'(HDISP - 1)) && (y_q == YW'(VDISP - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      beat_q       <= '0;
      gap_q        <= '0;
      bar_pos_q    <= '0;
      bar_q        <= '0;
      pat_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
      cyc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      bar_pos_q    <= bar_pos_d;
      bar_q        <= bar_d;
      pat_q        <= pat_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
      cyc_q        <= cyc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    bar_pos_d    = bar_pos_q;
    bar_d        = bar_q;
    pat_d        = pat_q;
    adr_d        = adr_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    last_d       = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_WRITE;
          pat_d     = pattern_sel;
          x_d       = '0;
          y_d       = '0;
          adr_d     = '0;
          beat_d    = '0;
          bar_pos_d = '0;
          bar_d     = '0;
          last_d    = 1'b0;
        end
      end
      S_WRITE: begin
        if (ack) begin
          adr_d  = adr_q + 32'd4;
          beat_d = beat_q + 1'b1;
          // The colour-bar index tracks x incrementally so no divider is needed.
          if (x_q == XW'(HDISP - 1)) begin
            x_d       = '0;
            bar_pos_d = '0;
            bar_d     = '0;
            y_d       = (y_q == YW'(VDISP - 1)) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
            if (bar_pos_q == PW'(BAR_LEN - 1)) begin
              bar_pos_d = '0;
              bar_d     = bar_q + 3'd1;
            end else begin
              bar_pos_d = bar_pos_q + 1'b1;
            end
          end
          if (last_pixel) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            last_d       = 1'b1;
            beat_d       = '0;
            gap_d        = '0;
            state_d      = S_GAP;
          end else if (beat_q == BW'(BURST - 1)) begin
            beat_d  = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) begin
          state_d = last_q ? S_IDLE : S_WRITE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel data is computed from the next coordinates so it is registered alongside adr.
  always_comb begin
    rgb        = '0;
    load_pixel = ((state_q == S_IDLE) && enable) || ((state_q == S_WRITE) && ack);
    cyc_d      = (state_d == S_WRITE);
    unique case (pat_d)
      2'd0: begin
        unique case (bar_d)
          3'd0: rgb = 24'hFFFFFF;
          3'd1: rgb = 24'hFFFF00;
          3'd2: rgb = 24'h00FFFF;
          3'd3: rgb = 24'h00FF00;
          3'd4: rgb = 24'hFF00FF;
          3'd5: rgb = 24'hFF0000;
          3'd6: rgb = 24'h0000FF;
          3'd7: rgb = 24'h000000;
          default: rgb = 24'h000000;
        endcase
      end
      2'd1: rgb = ((x_d[3:0] == 4'd0) || (y_d[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
      2'd2: rgb = {x_d[7:0], y_d[7:0], frame_cnt_d};
      2'd3: rgb = (x_d[5] ^ y_d[5]) ? 24'hFFFFFF : 24'h000000;
      default: rgb = 24'h000000;
    endcase
    dat_d = load_pixel ? {8'h00, rgb} : dat_q;
  end

  assign cyc        = cyc_q;
  assign stb        = cyc_q;
  assign we         = 1'b1;
  assign adr        = adr_q;
  assign dat_ms     = dat_q;
  assign sel        = 4'hF;
  assign cti        = 3'b000;
  assign bte        = 2'b00;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Self-checking bench for pattern_writer on a 16x4 frame with 8-ack tenures,
// using a small Wishbone slave with programmable ack latency and a pixel capture buffer.
module tb_pattern_writer;

  localparam int HD   = 16;
  localparam int VD   = 4;
  localparam int BR   = 8;
  localparam int GP   = 2;
  localparam int NPIX = HD * VD;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        cyc, stb, we, ack, frame_done;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  pattern_writer #(.HDISP(HD), .VDISP(VD), .BURST(BR), .GAP(GP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .pattern_sel(pattern_sel),
    .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms), .sel(sel),
    .cti(cti), .bte(bte), .ack(ack), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  // Slave: acks after ack_delay wait cycles of a pending strobe.
  int ack_delay = 0;
  int wait_cnt  = 0;
  assign ack = stb && (wait_cnt >= ack_delay);

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) wait_cnt <= 0;
    else if (stb && !ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Capture of accepted writes plus bus-protocol bookkeeping.
  logic [31:0] cap_adr [256];
  logic [31:0] cap_dat [256];
  int          ncap = 0;
  int          fd_count = 0;
  bit          prev_last = 0;
  bit          held = 0;
  logic [31:0] hold_adr, hold_dat;
  bit          prev_cyc = 0;
  int          ten_acks = 0;
  int          low_run = 0;
  int          ten_q[$];
  int          low_q[$];

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      fd_count  = 0;
      prev_last = 0;
      held      = 0;
    end else begin
      if (frame_done || prev_last) check_val("frame_done_pulse", 32'(frame_done), 32'(prev_last));
      if (frame_done) begin
        check_val("frame_cnt_at_done", 32'(frame_cnt), 32'((fd_count + 1) % 256));
        fd_count++;
      end
      prev_last = 0;
      if (cyc && stb && ack) begin
        if (held) begin
          check_val("hold_adr", adr, hold_adr);
          check_val("hold_dat", dat_ms, hold_dat);
        end
        if (ncap < 256) begin
          cap_adr[ncap] = adr;
          cap_dat[ncap] = dat_ms;
        end
        ncap++;
        prev_last = (adr == 32'(4 * (NPIX - 1)));
        held = 0;
        ten_acks++;
      end else if (stb) begin
        if (held) begin
          check_val("hold_adr", adr, hold_adr);
          check_val("hold_dat", dat_ms, hold_dat);
        end
        held = 1;
        hold_adr = adr;
        hold_dat = dat_ms;
      end
      if (cyc && !prev_cyc) begin
        low_q.push_back(low_run);
        low_run = 0;
      end
      if (!cyc && prev_cyc) begin
        ten_q.push_back(ten_acks);
        ten_acks = 0;
      end
      if (!cyc) low_run++;
      prev_cyc = cyc;
    end
  end

  function automatic logic [31:0] model_pix(input int x, input int y, input int pat, input int fc);
    logic [23:0] bars [8];
    logic [23:0] rgb;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (pat)
      0:       rgb = bars[x / (HD / 8)];
      1:       rgb = ((x % 16) == 0 || (y % 16) == 0) ? 24'hFFFFFF : 24'h000000;
      2:       rgb = {8'(x), 8'(y), 8'(fc)};
      default: rgb = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
    endcase
    return {8'h00, rgb};
  endfunction

  task automatic check_frame(input int base, input int pat, input int fc, input string name);
    int errs = 0;
    int adr_errs = 0;
    logic [31:0] sum_got = '0;
    logic [31:0] sum_exp = '0;
    for (int i = 0; i < NPIX; i++) begin
      logic [31:0] e;
      e = model_pix(i % HD, i / HD, pat, fc);
      if (cap_dat[base + i] !== e) errs++;
      if (cap_adr[base + i] !== 32'(4 * i)) adr_errs++;
      sum_got = sum_got + cap_dat[base + i];
      sum_exp = sum_exp + e;
    end
    check_val({name, "_pix_errs"}, 32'(errs), 32'd0);
    check_val({name, "_adr_errs"}, 32'(adr_errs), 32'd0);
    check_val({name, "_checksum"}, sum_got, sum_exp);
  endtask

  typedef struct {
    int          test;
    int          frame;
    int          x;
    int          y;
    logic [31:0] want;
  } vec_t;
  vec_t vecs[$];

  task automatic check_table(input int test_id);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].test == test_id) begin
        int idx;
        idx = vecs[i].frame * NPIX + vecs[i].y * HD + vecs[i].x;
        check_val($sformatf("t%0d_f%0d_pix(%0d,%0d)", test_id, vecs[i].frame, vecs[i].x, vecs[i].y),
                  cap_dat[idx], vecs[i].want);
      end
    end
  endtask

  task automatic wait_caps(input int n, input int budget, input string name);
    int c = 0;
    while (ncap < n && c < budget) begin
      @(posedge sys_clk); #1;
      c++;
    end
    total++;
    if (ncap < n) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d writes want %0d", name, ncap, n);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int c = 0;
    while (fd_count < n && c < budget) begin
      @(posedge sys_clk); #1;
      c++;
    end
    total++;
    if (fd_count < n) begin
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d frames want %0d", name, fd_count, n);
    end
  endtask

  task automatic clear_capture();
    ncap     = 0;
    ten_acks = 0;
    low_run  = 0;
    ten_q.delete();
    low_q.delete();
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    enable  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    clear_capture();
  endtask

  task automatic pulse_enable(input logic [1:0] pat);
    @(negedge sys_clk);
    pattern_sel = pat;
    enable = 1'b1;
    @(negedge sys_clk);
    enable = 1'b0;
  endtask

  initial begin
    vecs.push_back('{1, 0,  0, 0, 32'h00FFFFFF});
    vecs.push_back('{1, 0,  2, 0, 32'h00FFFF00});
    vecs.push_back('{1, 0,  5, 1, 32'h0000FFFF});
    vecs.push_back('{1, 0,  6, 2, 32'h0000FF00});
    vecs.push_back('{1, 0,  8, 3, 32'h00FF00FF});
    vecs.push_back('{1, 0, 11, 0, 32'h00FF0000});
    vecs.push_back('{1, 0, 12, 1, 32'h000000FF});
    vecs.push_back('{1, 0, 15, 3, 32'h00000000});
    vecs.push_back('{2, 0,  0, 0, 32'h00FFFFFF});
    vecs.push_back('{2, 0,  3, 0, 32'h00FFFFFF});
    vecs.push_back('{2, 0,  0, 2, 32'h00FFFFFF});
    vecs.push_back('{2, 0,  5, 2, 32'h00000000});
    vecs.push_back('{2, 0, 15, 3, 32'h00000000});
    vecs.push_back('{3, 0, 15, 3, 32'h000F0300});
    vecs.push_back('{3, 1,  7, 1, 32'h00070101});
    vecs.push_back('{3, 2,  3, 2, 32'h00030202});
    vecs.push_back('{4, 0,  0, 3, 32'h00FFFFFF});
    vecs.push_back('{4, 0,  5, 3, 32'h00000000});
    vecs.push_back('{4, 1,  0, 0, 32'h00000000});
    vecs.push_back('{4, 1,  0, 3, 32'h00000000});
    vecs.push_back('{4, 1,  3, 0, 32'h00000000});

    sys_rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    apply_reset();

    check_val("rst_cyc", 32'(cyc), 32'd0);
    check_val("rst_stb", 32'(stb), 32'd0);
    check_val("rst_adr", adr, 32'd0);
    check_val("rst_dat", dat_ms, 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("const_we", 32'(we), 32'd1);
    check_val("const_sel", 32'(sel), 32'hF);
    check_val("const_cti", 32'(cti), 32'd0);
    check_val("const_bte", 32'(bte), 32'd0);

    // Colour bars, always-ack slave, enable held for one cycle only.
    @(negedge sys_clk);
    pattern_sel = 2'd0;
    enable = 1'b1;
    check_val("a_cyc_before", 32'(cyc), 32'd0);
    @(posedge sys_clk); #1;
    check_val("a_cyc_start", 32'(cyc), 32'd1);
    check_val("a_adr_start", adr, 32'd0);
    check_val("a_dat_start", dat_ms, 32'h00FFFFFF);
    @(negedge sys_clk);
    enable = 1'b0;
    wait_frames(1, 500, "a_frame");
    repeat (10) @(posedge sys_clk);
    #1;
    check_val("a_writes", 32'(ncap), 32'(NPIX));
    check_val("a_idle_cyc", 32'(cyc), 32'd0);
    check_val("a_frame_cnt", 32'(frame_cnt), 32'd1);
    check_val("a_frame_pulses", 32'(fd_count), 32'd1);
    check_val("a_tenures", 32'(ten_q.size()), 32'(NPIX / BR));
    for (int i = 0; i < ten_q.size(); i++) check_val($sformatf("a_tenure%0d_acks", i), 32'(ten_q[i]), 32'(BR));
    for (int i = 1; i < low_q.size(); i++) check_val($sformatf("a_gap%0d_len", i), 32'(low_q[i]), 32'(GP));
    check_frame(0, 0, 0, "a");
    check_table(1);

    // Grid with a slow slave: outputs must hold while waiting for ack.
    apply_reset();
    ack_delay = 3;
    pulse_enable(2'd1);
    wait_frames(1, 2000, "b_frame");
    repeat (5) @(posedge sys_clk);
    #1;
    check_val("b_writes", 32'(ncap), 32'(NPIX));
    check_frame(0, 1, 0, "b");
    check_table(2);
    ack_delay = 0;

    // Gradient over three back-to-back frames.
    apply_reset();
    @(negedge sys_clk);
    pattern_sel = 2'd2;
    enable = 1'b1;
    wait_frames(3, 1500, "c_frames");
    enable = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    check_val("c_frame_cnt", 32'(frame_cnt), 32'd3);
    check_val("c_writes", 32'(ncap), 32'(3 * NPIX));
    check_frame(0, 2, 0, "c0");
    check_frame(NPIX, 2, 1, "c1");
    check_frame(2 * NPIX, 2, 2, "c2");
    check_table(3);

    // Reset in the middle of a tenure, with a non-zero frame count.
    clear_capture();
    pulse_enable(2'd0);
    wait_caps(20, 200, "f_caps");
    @(negedge sys_clk);
    check_val("f_cyc_before_rst", 32'(cyc), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check_val("f_rst_cyc", 32'(cyc), 32'd0);
    check_val("f_rst_stb", 32'(stb), 32'd0);
    check_val("f_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("f_rst_adr", adr, 32'd0);
    repeat (2) @(posedge sys_clk);
    #2 sys_rst = 1'b0;
    clear_capture();
    pulse_enable(2'd0);
    wait_caps(1, 50, "f_restart");
    check_val("f_restart_adr", cap_adr[0], 32'd0);
    check_val("f_restart_dat", cap_dat[0], 32'h00FFFFFF);
    wait_frames(1, 500, "f_frame");
    #20;
    check_val("f_frame_cnt", 32'(frame_cnt), 32'd1);

    // Pattern select changed mid-frame takes effect only on the next frame.
    apply_reset();
    @(negedge sys_clk);
    pattern_sel = 2'd1;
    enable = 1'b1;
    wait_caps(20, 200, "d_caps");
    pattern_sel = 2'd3;
    wait_frames(2, 1000, "d_frames");
    enable = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    check_val("d_writes", 32'(ncap), 32'(2 * NPIX));
    check_frame(0, 1, 0, "d0");
    check_frame(NPIX, 3, 1, "d1");
    check_table(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
